// File: rtl/ysyx_22040750_axi_pkg.sv
// Shared definitions for the AXI4 read arbiter: FSM encoding and AR/R payload layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ysyx_22040750_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // AR payload is {addr, len[7:0], size[2:0], burst[1:0]}, MSB first.
    localparam int AR_BURST_LSB = 0;
    localparam int AR_BURST_W   = 2;
    localparam int AR_SIZE_LSB  = 2;
    localparam int AR_SIZE_W    = 3;
    localparam int AR_LEN_LSB   = 5;
    localparam int AR_LEN_W     = 8;
    localparam int AR_ADDR_LSB  = 13;
    localparam int AR_CTRL_W    = 13;

    // R payload is {rlast, rdata}; rlast sits at bit AXI_DATA_W.
    localparam int AXI_DATA_W   = 64;
    localparam int AXI_R_W      = AXI_DATA_W + 1;

    function automatic logic [AR_LEN_W-1:0] ar_len_of(input logic [AR_CTRL_W-1:0] ctrl);
        return ctrl[AR_LEN_LSB +: AR_LEN_W];
    endfunction

endpackage

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-request arbiter: one-hot grant, round-robin on ties (or dcache strict priority).
// Latency: grant is combinational from req; rr_last updates on the clock after take.
// Backpressure: none; caller asserts take only when it consumes the grant.
//
// Ports: clk, rst_n (async active-low), req[1:0], take (grant consumed), gnt[1:0] one-hot.
// Build option: ARB_DCACHE_PRIO_EN gives req[1] strict priority and drops rr_last.
module ysyx_22040750_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

`ifdef ARB_DCACHE_PRIO_EN
    logic unused_prio;
    assign unused_prio = ^{clk, rst_n, take};

    always_comb begin
        gnt = 2'b00;
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
    end
`else
    // rr_last = index of the last granted requester; resets to 1 so req[0] wins the first tie.
    logic rr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_last <= 1'b1;
        else if (take) rr_last <= gnt[1];
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/ysyx_22040750_axi_rd_arbiter.sv
// Two-master AXI4 read arbiter (m0 icache, m1 dcache) onto one downstream read port.
// Latency: AR request in cycle N -> O_bus_arvalid in N+1; R beats pass through combinationally.
// Backpressure: one burst outstanding; arready held low while busy, R ready follows granted master.
//
// Ports: I_clk, I_rst (async active-low); per master AR payload/valid/ready and R {rlast,rdata}/valid/ready;
//        downstream O_bus_ar*/I_bus_r*; O_len_err pulses one cycle after a beat whose rlast disagrees with arlen.
// Build option: ARB_DCACHE_PRIO_EN selects dcache strict priority instead of round-robin.
module ysyx_22040750_axi_rd_arbiter
    import ysyx_22040750_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int AR_W   = ADDR_W + 13
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [AR_W-1:0]   I_m0_ar,
    input  logic              I_m0_arvalid,
    output logic              O_m0_arready,
    output logic [DATA_W:0]   O_m0_r,
    output logic              O_m0_rvalid,
    input  logic              I_m0_rready,
    input  logic [AR_W-1:0]   I_m1_ar,
    input  logic              I_m1_arvalid,
    output logic              O_m1_arready,
    output logic [DATA_W:0]   O_m1_r,
    output logic              O_m1_rvalid,
    input  logic              I_m1_rready,
    output logic [AR_W-1:0]   O_bus_ar,
    output logic              O_bus_arvalid,
    input  logic              I_bus_arready,
    input  logic [DATA_W:0]   I_bus_r,
    input  logic              I_bus_rvalid,
    output logic              O_bus_rready,
    output logic              O_len_err
);

    arb_state_e          state_q, state_d;
    logic                grant_q;      // granted master index; only meaningful outside IDLE
    logic [AR_LEN_W-1:0] saved_len_q;
    logic [AR_LEN_W-1:0] cnt_q;        // beats already accepted in this burst
    logic [AR_W-1:0]     bus_ar_q;
    logic                len_err_q;

    logic [1:0]          req, gnt;
    logic                take;
    logic [AR_W-1:0]     win_ar;
    logic                in_data, sel_rready, beat, rlast, len_bad;

    assign req  = {I_m1_arvalid, I_m0_arvalid};
    // Qualified by reset so no arready can escape while the block is held in reset.
    assign take = I_rst && (state_q == IDLE) && (req != 2'b00);

    ysyx_22040750_rr_arb2 u_arb (
        .clk   (I_clk),
        .rst_n (I_rst),
        .req   (req),
        .take  (take),
        .gnt   (gnt)
    );

    assign win_ar     = gnt[1] ? I_m1_ar : I_m0_ar;
    assign in_data    = (state_q == DATA);
    assign sel_rready = grant_q ? I_m1_rready : I_m0_rready;
    assign beat       = in_data && I_bus_rvalid && sel_rready;
    assign rlast      = I_bus_r[DATA_W];
    // A beat is bad exactly when rlast disagrees with "this is beat number arlen".
    assign len_bad    = beat && (rlast != (cnt_q == saved_len_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ADDR;
            ADDR:    if (I_bus_arready) state_d = DATA;
            DATA:    if (beat && rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            saved_len_q <= '0;
            cnt_q       <= '0;
            bus_ar_q    <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_err_q <= len_bad;
            if (take) begin
                grant_q     <= gnt[1];
                bus_ar_q    <= win_ar;
                saved_len_q <= ar_len_of(win_ar[AR_CTRL_W-1:0]);
                cnt_q       <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign O_m0_arready  = take && gnt[0];
    assign O_m1_arready  = take && gnt[1];
    assign O_bus_ar      = bus_ar_q;
    assign O_bus_arvalid = (state_q == ADDR);
    assign O_bus_rready  = in_data && sel_rready;
    assign O_len_err     = len_err_q;

    // Non-granted master sees zero data as well as rvalid=0, keeping idle outputs quiet.
    assign O_m0_rvalid = in_data && !grant_q && I_bus_rvalid;
    assign O_m1_rvalid = in_data &&  grant_q && I_bus_rvalid;
    assign O_m0_r      = (in_data && !grant_q) ? I_bus_r : '0;
    assign O_m1_r      = (in_data &&  grant_q) ? I_bus_r : '0;

endmodule

// File: tb/tb_ysyx_22040750_axi_rd_arbiter.sv
`timescale 1ns/1ps
module tb_ysyx_22040750_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int AR_W   = ADDR_W + 13;

`ifdef ARB_DCACHE_PRIO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic              I_clk = 1'b0;
    logic              I_rst;
    logic [AR_W-1:0]   I_m0_ar, I_m1_ar;
    logic              I_m0_arvalid, I_m1_arvalid;
    logic              O_m0_arready, O_m1_arready;
    logic [DATA_W:0]   O_m0_r, O_m1_r;
    logic              O_m0_rvalid, O_m1_rvalid;
    logic              I_m0_rready, I_m1_rready;
    logic [AR_W-1:0]   O_bus_ar;
    logic              O_bus_arvalid, I_bus_arready;
    logic [DATA_W:0]   I_bus_r;
    logic              I_bus_rvalid, O_bus_rready, O_len_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 I_clk = ~I_clk;

    ysyx_22040750_axi_rd_arbiter dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_m0_ar(I_m0_ar), .I_m0_arvalid(I_m0_arvalid), .O_m0_arready(O_m0_arready),
        .O_m0_r(O_m0_r), .O_m0_rvalid(O_m0_rvalid), .I_m0_rready(I_m0_rready),
        .I_m1_ar(I_m1_ar), .I_m1_arvalid(I_m1_arvalid), .O_m1_arready(O_m1_arready),
        .O_m1_r(O_m1_r), .O_m1_rvalid(O_m1_rvalid), .I_m1_rready(I_m1_rready),
        .O_bus_ar(O_bus_ar), .O_bus_arvalid(O_bus_arvalid), .I_bus_arready(I_bus_arready),
        .I_bus_r(I_bus_r), .I_bus_rvalid(I_bus_rvalid), .O_bus_rready(O_bus_rready),
        .O_len_err(O_len_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    function automatic logic [AR_W-1:0] ar_pay(input logic [31:0] a, input logic [7:0] len);
        return {a, len, 3'd3, 2'd1};
    endfunction

    // Entered in the IDLE cycle where master m should win; drives the downstream side of
    // one burst and returns in the first IDLE cycle after rlast.
    task automatic serve(input int m, input logic [AR_W-1:0] pay, input int ar_wait,
                         input int nbeats, input int stall_at, input int stall_len,
                         input bit exp_err);
        logic [DATA_W:0] rb;
        int beat, stall_cnt, cyc;
        bit stalled;
        #1;
        chk("arready_win",  m ? O_m1_arready : O_m0_arready, 1);
        chk("arready_lose", m ? O_m0_arready : O_m1_arready, 0);
        chk("arvalid_idle", O_bus_arvalid, 0);
        tick();
        if (m != 0) I_m1_arvalid = 1'b0; else I_m0_arvalid = 1'b0;
        for (int w = 0; w <= ar_wait; w++) begin
            I_bus_arready = (w == ar_wait);
            #1;
            chk("bus_arvalid", O_bus_arvalid, 1);
            chk("bus_ar", O_bus_ar, pay);
            chk("arready_addr", O_m0_arready | O_m1_arready, 0);
            chk("rready_addr", O_bus_rready, 0);
            chk("rvalid_addr", O_m0_rvalid | O_m1_rvalid, 0);
            tick();
        end
        I_bus_arready = 1'b0;
        beat = 0; stall_cnt = 0; cyc = 0;
        while (beat < nbeats && cyc < 64) begin
            stalled = (beat == stall_at) && (stall_cnt < stall_len);
            rb = {beat == nbeats - 1, 32'(m + 1), 32'hCAFE_0000 + 32'(beat)};
            I_bus_rvalid = 1'b1;
            I_bus_r = rb;
            if (m != 0) begin I_m1_rready = !stalled; I_m0_rready = 1'b1; end
            else        begin I_m0_rready = !stalled; I_m1_rready = 1'b1; end
            #1;
            chk("rvalid_win",  m ? O_m1_rvalid : O_m0_rvalid, 1);
            chk("rvalid_lose", m ? O_m0_rvalid : O_m1_rvalid, 0);
            chk("r_dat", m ? O_m1_r : O_m0_r, rb);
            chk("bus_rready", O_bus_rready, !stalled);
            chk("arready_busy", O_m0_arready | O_m1_arready, 0);
            chk("len_err_mid", O_len_err, 0);
            tick();
            if (stalled) stall_cnt++; else beat++;
            cyc++;
        end
        chk("burst_done", beat, nbeats);
        // Back in IDLE: leave R traffic on the bus to show it is ignored.
        I_bus_r = '1;
        I_m0_rready = 1'b1;
        I_m1_rready = 1'b1;
        #1;
        chk("len_err", O_len_err, exp_err);
        chk("idle_arvalid", O_bus_arvalid, 0);
        chk("idle_rready", O_bus_rready, 0);
        chk("idle_rvalid", O_m0_rvalid | O_m1_rvalid, 0);
    endtask

    logic [AR_W-1:0] p0, p1, pa;

    initial begin
        p0 = ar_pay(32'h8000_0000, 8'd1);
        p1 = ar_pay(32'h8000_1000, 8'd1);
        I_rst = 1'b0;
        I_m0_ar = p0; I_m1_ar = p1;
        I_m0_arvalid = 1'b1; I_m1_arvalid = 1'b1;
        I_m0_rready = 1'b1; I_m1_rready = 1'b1;
        I_bus_arready = 1'b1; I_bus_r = '1; I_bus_rvalid = 1'b1;
        #12;
        chk("rst_m0_arready", O_m0_arready, 0);
        chk("rst_m1_arready", O_m1_arready, 0);
        chk("rst_bus_arvalid", O_bus_arvalid, 0);
        chk("rst_bus_ar", O_bus_ar, 0);
        chk("rst_bus_rready", O_bus_rready, 0);
        chk("rst_rvalid", O_m0_rvalid | O_m1_rvalid, 0);
        chk("rst_len_err", O_len_err, 0);
        I_bus_arready = 1'b0; I_bus_rvalid = 1'b0;
        I_rst = 1'b1;

        // Tie from reset, then the first winner re-requests while the other still waits.
        serve(FIRST, FIRST ? p1 : p0, 0, 2, -1, 0, 0);
        if (FIRST != 0) I_m1_arvalid = 1'b1; else I_m0_arvalid = 1'b1;
        serve(1, p1, 1, 2, -1, 0, 0);
        serve(0, p0, 0, 2, -1, 0, 0);

        // m0 alone, len=3, downstream accepts AR after two wait cycles.
        tick();
        I_bus_rvalid = 1'b0;
        pa = ar_pay(32'h8000_0000, 8'd3);
        I_m0_ar = pa; I_m0_arvalid = 1'b1;
        serve(0, pa, 2, 4, -1, 0, 0);

        // m1 burst with a 3-cycle rready stall on beat 1.
        tick();
        pa = ar_pay(32'h8000_2000, 8'd3);
        I_m1_ar = pa; I_m1_arvalid = 1'b1;
        serve(1, pa, 0, 4, 1, 3, 0);

        // len=3 but rlast on the second beat: one-cycle error pulse.
        tick();
        pa = ar_pay(32'h8000_3000, 8'd3);
        I_m0_ar = pa; I_m0_arvalid = 1'b1;
        serve(0, pa, 1, 2, -1, 0, 1);
        tick();
        chk("len_err_one_cycle", O_len_err, 0);

        // Reset asserted in DATA after the first beat.
        I_bus_rvalid = 1'b0;
        pa = ar_pay(32'h8000_4000, 8'd3);
        I_m0_ar = pa; I_m0_arvalid = 1'b1;
        tick();
        I_m0_arvalid = 1'b0; I_bus_arready = 1'b1;
        tick();
        I_bus_arready = 1'b0;
        I_bus_rvalid = 1'b1; I_bus_r = {1'b0, 64'h1111}; I_m0_rready = 1'b1;
        #1;
        chk("pre_rst_rvalid", O_m0_rvalid, 1);
        tick();
        I_bus_r = {1'b0, 64'h2222};
        I_m0_ar = p0; I_m1_ar = p1;
        I_m0_arvalid = 1'b1; I_m1_arvalid = 1'b1;
        #1;
        I_rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", O_m0_rvalid | O_m1_rvalid, 0);
        chk("mid_rst_r", O_m0_r, 0);
        chk("mid_rst_rready", O_bus_rready, 0);
        chk("mid_rst_bus_ar", O_bus_ar, 0);
        chk("mid_rst_arvalid", O_bus_arvalid, 0);
        chk("mid_rst_arready", O_m0_arready | O_m1_arready, 0);
        #1;
        I_rst = 1'b1;
        serve(FIRST, FIRST ? p1 : p0, 0, 2, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_axi_rd_arbiter.md
Name: ysyx_22040750_axi_rd_arbiter

Overview:
- Two-master AXI4 read-channel arbiter: master 0 = icache refill, master 1 = dcache refill/uncached load.
- Both share one downstream read port toward slave_crossbar.
- Grants one master per burst, forwards its AR, steers R beats back until the rlast handshake, and checks beat count against arlen.

Parameters:
- ADDR_W, 32, AR address width.
- DATA_W, 64, R data width.
- AR_W, ADDR_W+13, packed AR payload {addr, len[7:0], size[2:0], burst[1:0]}, MSB first.

Ports:
- I_clk  in  1  single clock; all logic rising-edge.
- I_rst  in  1  asynchronous, active-low reset.
- I_m0_ar  in  AR_W  icache AR payload.
- I_m0_arvalid  in  1  icache AR valid.
- O_m0_arready  out  1  icache AR accepted.
- O_m0_r  out  DATA_W+1  {rlast, rdata} to icache.
- O_m0_rvalid  out  1  R beat valid to icache.
- I_m0_rready  in  1  icache R ready.
- I_m1_ar, I_m1_arvalid, O_m1_arready, O_m1_r, O_m1_rvalid, I_m1_rready: same as m0, for dcache.
- O_bus_ar  out  AR_W  registered AR payload downstream.
- O_bus_arvalid  out  1  downstream AR valid.
- I_bus_arready  in  1  downstream AR ready.
- I_bus_r  in  DATA_W+1  {rlast, rdata} from downstream.
- I_bus_rvalid  in  1  downstream R valid.
- O_bus_rready  out  1  downstream R ready.
- O_len_err  out  1  one-cycle pulse on burst length mismatch.

Behaviour:
- Reset (I_rst=0, async): state IDLE, grant=none, rr_last=1 (m0 wins first tie), beat counter=0, O_bus_ar=0. All valid/ready outputs 0. O_len_err=0.
- Reset mid-burst: burst abandoned, no further beats forwarded. The whole SoC is reset together.
- IDLE:
  - Pick a requester among arvalid masters; tie resolved round-robin by rr_last.
  - Winner's O_mX_arready=1 combinationally that cycle; payload captured into O_bus_ar.
  - grant<=X, rr_last<=X, saved_len<=payload len, cnt<=0, go to ADDR.
  - Latency: request in cycle N -> O_bus_arvalid high in cycle N+1.
- ADDR: O_bus_arvalid=1, payload held stable. On I_bus_arready, go to DATA.
- DATA:
  - O_bus_rready = I_mX_rready of the granted master. O_mX_rvalid = I_bus_rvalid. O_mX_r = I_bus_r. All combinational, zero-latency.
  - Non-granted master sees rvalid=0, arready=0.
  - On each beat handshake, cnt<=cnt+1 (8-bit, wraps at 255; max burst 256).
  - If rlast handshakes and cnt!=saved_len, or cnt==saved_len without rlast, O_len_err pulses next cycle.
  - On the rlast handshake, go to IDLE. The next grant is no earlier than the following cycle, so there is no back-to-back grant in the rlast cycle.
- AR is never accepted outside IDLE; arready stays 0 while busy.
- I_bus_rvalid in IDLE/ADDR: ignored, O_bus_rready=0.
- A single outstanding transaction, so R id/ordering is trivial.

Optional Feature:
- ARB_DCACHE_PRIO_EN defined: m1 (dcache) has strict priority over m0 whenever both are valid in IDLE; rr_last unused.
- Undefined: 2-way round-robin as above.

Decomposition:
- Package ysyx_22040750_axi_pkg holds:
  - state encoding IDLE/ADDR/DATA (2-bit);
  - field offsets and widths of the AR payload;
  - R payload width constant.
- One natural sub-module: ysyx_22040750_rr_arb2 (2-request round-robin grant, combinational grant plus rr_last register, honouring ARB_DCACHE_PRIO_EN).

Test Plan:
- m0 only, addr 0x8000_0000, len=3, downstream arready after 2 cycles, 4 beats, rlast on 4th -> O_bus_arvalid from cycle N+1 to handshake; icache receives 4 beats in order; O_len_err stays 0; back to IDLE.
- m0 and m1 both valid from reset, each len=1 -> m0 granted first, m1 granted after m0's rlast; repeat both -> m1 before m0 (round-robin alternation).
- Same as previous with ARB_DCACHE_PRIO_EN -> m1 always granted first.
- Granted master deasserts rready for 3 cycles mid-burst -> O_bus_rready low for those cycles, no beat lost or duplicated, cnt unchanged.
- len=3 but downstream rlast on beat 2 -> O_len_err pulses exactly one cycle; arbiter returns to IDLE.
- Assert I_rst low in DATA after beat 1 -> all outputs 0 immediately (async); after release, first m0/m1 tie grants m0.
